// File: rtl/sm83_ctl_seq.sv
// SM83 execute sequencer: steps per-op M-cycle slots, handles stall, HALT/wake
// and the 5-M-cycle interrupt dispatch; all strobes decode combinationally.
package sm83_ctl_pkg;
  typedef enum logic [3:0] {
    CTL_NOP, CTL_LD_R8_D8, CTL_LD_R8_R8, CTL_ALU_R8,
    CTL_LDPTR_A_R16, CTL_LDPTR_R8_HL, CTL_LDPTR_R16_A, CTL_LDPTR_HL_R8,
    CTL_LDPTR_HL_D8, CTL_JP_D16, CTL_JP_CC_D16, CTL_HALT
  } ctl_op_t;

  typedef logic [3:0] alu_op_t;

  typedef enum logic [1:0] {ADDR_PC, ADDR_GP16, ADDR_SP} addr_sel_t;

  typedef struct packed {
    logic inc_pc;
    logic mem_to_z;
    logic mem_to_w;
    logic mem_to_ir;
    logic mem_to_r8;
    logic capture_alu_res;
    logic r8_to_alu_op1;
    logic update_flags;
    logic r8_to_mem;
    logic z_to_mem;
    logic wz_to_pc;
    logic dec_sp;
    logic pch_to_mem;
    logic pcl_to_mem;
    logic vec_to_pc;
    logic irq_ack;
    logic clr_ime;
  } strb_t;
endpackage

module sm83_ctl_seq
  import sm83_ctl_pkg::*;
#(
  parameter int MAX_STEPS = 8,
  parameter int IDX_W     = $clog2(MAX_STEPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ctl_op_t          i_ctl_op,
  input  alu_op_t          i_decoded_alu_op,
  input  logic             i_cond_met,
  input  logic             i_stall,
  input  logic             i_int_req,
  input  logic             i_ime,
  output alu_op_t          o_alu_op,
  output addr_sel_t        o_addr_sel,
  output logic             o_inc_pc,
  output logic             o_mem_to_z,
  output logic             o_mem_to_w,
  output logic             o_mem_to_ir,
  output logic             o_mem_to_r8,
  output logic             o_capture_alu_res,
  output logic             o_r8_to_alu_op1,
  output logic             o_update_flags,
  output logic             o_r8_to_mem,
  output logic             o_z_to_mem,
  output logic             o_wz_to_pc,
  output logic             o_dec_sp,
  output logic             o_pch_to_mem,
  output logic             o_pcl_to_mem,
  output logic             o_vec_to_pc,
  output logic             o_irq_ack,
  output logic             o_clr_ime,
  output logic             o_halt,
  output logic [IDX_W-1:0] o_step_idx
);

  if (MAX_STEPS < 5) begin : g_bad_max_steps
    $error("sm83_ctl_seq: MAX_STEPS must be >= 5 to hold the IRQ dispatch");
  end

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED, ST_IRQ} state_t;

  localparam logic [IDX_W-1:0] S0 = 0;
  localparam logic [IDX_W-1:0] S1 = 1;
  localparam logic [IDX_W-1:0] S2 = 2;
  localparam logic [IDX_W-1:0] S3 = 3;

  state_t           r_state, w_nxt_state;
  logic [IDX_W-1:0] r_idx, w_nxt_idx;
  strb_t            w_s;
  addr_sel_t        w_addr;
  logic             w_fetch, w_take_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
    end
  end

  always_comb begin
    w_s         = '0;
    w_addr      = ADDR_PC;
    w_fetch     = 1'b0;
    w_take_irq  = 1'b0;
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx + IDX_W'(1);
    unique case (r_state)
      ST_BOOT: begin
        w_fetch     = 1'b1;
        w_nxt_state = ST_RUN;
      end
      ST_RUN: begin
        // The last slot of each sequence falls into the default fetch arm,
        // so an out-of-range idx can never run away.
        case (i_ctl_op)
          CTL_LD_R8_D8:
            if (r_idx == S0) begin
              w_s.mem_to_z = 1'b1;
              w_s.inc_pc   = 1'b1;
            end else begin
              w_s.r8_to_alu_op1   = 1'b1;
              w_s.capture_alu_res = 1'b1;
              w_fetch             = 1'b1;
            end
          CTL_LD_R8_R8: begin
            w_s.r8_to_alu_op1   = 1'b1;
            w_s.capture_alu_res = 1'b1;
            w_fetch             = 1'b1;
          end
          CTL_ALU_R8: begin
            w_s.r8_to_alu_op1   = 1'b1;
            w_s.capture_alu_res = 1'b1;
            w_s.update_flags    = 1'b1;
            w_fetch             = 1'b1;
          end
          CTL_LDPTR_A_R16, CTL_LDPTR_R8_HL:
            if (r_idx == S0) begin
              w_s.mem_to_z = 1'b1;
              w_addr       = ADDR_GP16;
            end else begin
              w_s.r8_to_alu_op1   = 1'b1;
              w_s.capture_alu_res = 1'b1;
              w_fetch             = 1'b1;
            end
          CTL_LDPTR_R16_A, CTL_LDPTR_HL_R8:
            if (r_idx == S0) begin
              w_s.r8_to_mem = 1'b1;
              w_addr        = ADDR_GP16;
            end else begin
              w_fetch = 1'b1;
            end
          CTL_LDPTR_HL_D8:
            case (r_idx)
              S0: begin
                w_s.mem_to_z = 1'b1;
                w_s.inc_pc   = 1'b1;
              end
              S1: begin
                w_s.z_to_mem = 1'b1;
                w_addr       = ADDR_GP16;
              end
              default: w_fetch = 1'b1;
            endcase
          CTL_JP_D16, CTL_JP_CC_D16:
            case (r_idx)
              S0: begin
                w_s.mem_to_z = 1'b1;
                w_s.inc_pc   = 1'b1;
              end
              S1: begin
                w_s.mem_to_w = 1'b1;
                w_s.inc_pc   = 1'b1;
              end
              // Untaken JP cc fetches a slot early: 3 M-cycles instead of 4.
              S2:
                if (i_ctl_op == CTL_JP_D16 || i_cond_met) w_s.wz_to_pc = 1'b1;
                else                                       w_fetch      = 1'b1;
              default: w_fetch = 1'b1;
            endcase
          CTL_HALT: begin
            w_nxt_state = ST_HALTED;
            w_nxt_idx   = '0;
          end
          default: w_fetch = 1'b1;
        endcase
        if (w_fetch && i_ime && i_int_req) begin
          w_take_irq  = 1'b1;
          w_s.clr_ime = 1'b1;
          w_nxt_state = ST_IRQ;
        end
      end
      ST_HALTED: begin
        w_nxt_idx = '0;
        if (i_int_req) begin
          w_s.clr_ime = i_ime;
          w_nxt_state = i_ime ? ST_IRQ : ST_BOOT;
        end
      end
      ST_IRQ:
        case (r_idx)
          S0: ;
          S1: w_s.dec_sp = 1'b1;
          S2: begin
            w_s.pch_to_mem = 1'b1;
            w_s.dec_sp     = 1'b1;
            w_addr         = ADDR_SP;
          end
          S3: begin
            w_s.pcl_to_mem = 1'b1;
            w_s.vec_to_pc  = 1'b1;
            w_s.irq_ack    = 1'b1;
            w_addr         = ADDR_SP;
          end
          default: begin
            w_fetch     = 1'b1;
            w_nxt_state = ST_RUN;
          end
        endcase
      default: w_nxt_state = ST_BOOT;
    endcase
    if (w_fetch) begin
      w_nxt_idx = '0;
      if (!w_take_irq) begin
        w_s.mem_to_ir = 1'b1;
        w_s.inc_pc    = 1'b1;
      end
    end
    // Stall wins over everything, including IRQ entry and HALT wake.
    if (i_stall) begin
      w_s         = '0;
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
    end
  end

  assign o_alu_op          = i_decoded_alu_op;
  assign o_addr_sel        = w_addr;
  assign o_inc_pc          = w_s.inc_pc;
  assign o_mem_to_z        = w_s.mem_to_z;
  assign o_mem_to_w        = w_s.mem_to_w;
  assign o_mem_to_ir       = w_s.mem_to_ir;
  assign o_mem_to_r8       = w_s.mem_to_r8;
  assign o_capture_alu_res = w_s.capture_alu_res;
  assign o_r8_to_alu_op1   = w_s.r8_to_alu_op1;
  assign o_update_flags    = w_s.update_flags;
  assign o_r8_to_mem       = w_s.r8_to_mem;
  assign o_z_to_mem        = w_s.z_to_mem;
  assign o_wz_to_pc        = w_s.wz_to_pc;
  assign o_dec_sp          = w_s.dec_sp;
  assign o_pch_to_mem      = w_s.pch_to_mem;
  assign o_pcl_to_mem      = w_s.pcl_to_mem;
  assign o_vec_to_pc       = w_s.vec_to_pc;
  assign o_irq_ack         = w_s.irq_ack;
  assign o_clr_ime         = w_s.clr_ime;
  assign o_halt            = (r_state == ST_HALTED);
  assign o_step_idx        = r_idx;

endmodule

// File: tb/tb_sm83_ctl_seq.sv
// Scoreboard bench for sm83_ctl_seq: each driven cycle queues its expected
// output word, which is popped and compared on the following falling edge.
module tb_sm83_ctl_seq;
  import sm83_ctl_pkg::*;

  localparam logic [17:0] INC = 18'd1 << 17;
  localparam logic [17:0] MZ  = 18'd1 << 16;
  localparam logic [17:0] MW  = 18'd1 << 15;
  localparam logic [17:0] MIR = 18'd1 << 14;
  localparam logic [17:0] CAP = 18'd1 << 12;
  localparam logic [17:0] R8A = 18'd1 << 11;
  localparam logic [17:0] UPD = 18'd1 << 10;
  localparam logic [17:0] ZM  = 18'd1 << 8;
  localparam logic [17:0] WZ  = 18'd1 << 7;
  localparam logic [17:0] DSP = 18'd1 << 6;
  localparam logic [17:0] PCH = 18'd1 << 5;
  localparam logic [17:0] PCL = 18'd1 << 4;
  localparam logic [17:0] VEC = 18'd1 << 3;
  localparam logic [17:0] ACK = 18'd1 << 2;
  localparam logic [17:0] CLR = 18'd1 << 1;
  localparam logic [17:0] HLT = 18'd1;
  localparam logic [17:0] F   = MIR | INC;

  logic      clk, rst_n;
  ctl_op_t   i_ctl_op;
  alu_op_t   i_decoded_alu_op, o_alu_op;
  logic      i_cond_met, i_stall, i_int_req, i_ime;
  addr_sel_t o_addr_sel;
  logic o_inc_pc, o_mem_to_z, o_mem_to_w, o_mem_to_ir, o_mem_to_r8;
  logic o_capture_alu_res, o_r8_to_alu_op1, o_update_flags, o_r8_to_mem;
  logic o_z_to_mem, o_wz_to_pc, o_dec_sp, o_pch_to_mem, o_pcl_to_mem;
  logic o_vec_to_pc, o_irq_ack, o_clr_ime, o_halt;
  logic [2:0] o_step_idx;

  int n_chk = 0;
  int n_fail = 0;
  logic [26:0] exp_q[$];
  string       tag_q[$];
  logic [26:0] w_got;

  sm83_ctl_seq dut (
    .clk(clk), .rst_n(rst_n), .i_ctl_op(i_ctl_op),
    .i_decoded_alu_op(i_decoded_alu_op), .i_cond_met(i_cond_met),
    .i_stall(i_stall), .i_int_req(i_int_req), .i_ime(i_ime),
    .o_alu_op(o_alu_op), .o_addr_sel(o_addr_sel), .o_inc_pc(o_inc_pc),
    .o_mem_to_z(o_mem_to_z), .o_mem_to_w(o_mem_to_w),
    .o_mem_to_ir(o_mem_to_ir), .o_mem_to_r8(o_mem_to_r8),
    .o_capture_alu_res(o_capture_alu_res), .o_r8_to_alu_op1(o_r8_to_alu_op1),
    .o_update_flags(o_update_flags), .o_r8_to_mem(o_r8_to_mem),
    .o_z_to_mem(o_z_to_mem), .o_wz_to_pc(o_wz_to_pc), .o_dec_sp(o_dec_sp),
    .o_pch_to_mem(o_pch_to_mem), .o_pcl_to_mem(o_pcl_to_mem),
    .o_vec_to_pc(o_vec_to_pc), .o_irq_ack(o_irq_ack), .o_clr_ime(o_clr_ime),
    .o_halt(o_halt), .o_step_idx(o_step_idx)
  );

  assign w_got = {o_alu_op, 2'(o_addr_sel), o_inc_pc, o_mem_to_z, o_mem_to_w,
                  o_mem_to_ir, o_mem_to_r8, o_capture_alu_res, o_r8_to_alu_op1,
                  o_update_flags, o_r8_to_mem, o_z_to_mem, o_wz_to_pc, o_dec_sp,
                  o_pch_to_mem, o_pcl_to_mem, o_vec_to_pc, o_irq_ack, o_clr_ime,
                  o_halt, o_step_idx};

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk(tag_q.pop_front(), 32'(w_got), 32'(exp_q.pop_front()));
  end

  task automatic cyc(input string tag, input ctl_op_t op, input logic cnd, input logic stl,
                     input logic irq, input logic ie, input logic [17:0] m,
                     input addr_sel_t a, input int id);
    alu_op_t alu;
    alu = alu_op_t'($urandom_range(0, 15));
    i_ctl_op = op; i_decoded_alu_op = alu; i_cond_met = cnd;
    i_stall = stl; i_int_req = irq; i_ime = ie;
    exp_q.push_back({alu, 2'(a), m, 3'(id)});
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc("rst_boot", CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);
    rst_n = 1'b1;
    cyc("boot",     CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);
    cyc("run_nop",  CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);

    cyc("ld_d8_s0", CTL_LD_R8_D8, 0, 0, 0, 0, MZ | INC, ADDR_PC, 0);
    cyc("ld_d8_s1", CTL_LD_R8_D8, 0, 0, 0, 0, R8A | CAP | F, ADDR_PC, 1);
    cyc("ldp_s0",   CTL_LDPTR_A_R16, 0, 0, 0, 0, MZ, ADDR_GP16, 0);
    cyc("ldp_s1",   CTL_LDPTR_A_R16, 0, 0, 0, 0, R8A | CAP | F, ADDR_PC, 1);

    cyc("jpnc_s0",  CTL_JP_CC_D16, 0, 0, 0, 0, MZ | INC, ADDR_PC, 0);
    cyc("jpnc_s1",  CTL_JP_CC_D16, 0, 0, 0, 0, MW | INC, ADDR_PC, 1);
    cyc("jpnc_s2",  CTL_JP_CC_D16, 0, 0, 0, 0, F, ADDR_PC, 2);
    cyc("jpc_s0",   CTL_JP_CC_D16, 1, 0, 0, 0, MZ | INC, ADDR_PC, 0);
    cyc("jpc_s1",   CTL_JP_CC_D16, 1, 0, 0, 0, MW | INC, ADDR_PC, 1);
    cyc("jpc_s2",   CTL_JP_CC_D16, 1, 0, 0, 0, WZ, ADDR_PC, 2);
    cyc("jpc_s3",   CTL_JP_CC_D16, 0, 0, 0, 0, F, ADDR_PC, 3);
    cyc("jp_after", CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);

    cyc("hld8_s0",  CTL_LDPTR_HL_D8, 0, 0, 0, 0, MZ | INC, ADDR_PC, 0);
    cyc("hld8_st1", CTL_LDPTR_HL_D8, 0, 1, 0, 0, '0, ADDR_GP16, 1);
    cyc("hld8_st2", CTL_LDPTR_HL_D8, 0, 1, 0, 0, '0, ADDR_GP16, 1);
    cyc("hld8_s1",  CTL_LDPTR_HL_D8, 0, 0, 0, 0, ZM, ADDR_GP16, 1);
    cyc("hld8_s2",  CTL_LDPTR_HL_D8, 0, 0, 0, 0, F, ADDR_PC, 2);

    cyc("irq_stall", CTL_ALU_R8, 0, 1, 1, 1, '0, ADDR_PC, 0);
    cyc("irq_entry", CTL_ALU_R8, 0, 0, 1, 1, R8A | CAP | UPD | CLR, ADDR_PC, 0);
    cyc("irq_i0",    CTL_ALU_R8, 0, 0, 0, 0, '0, ADDR_PC, 0);
    cyc("irq_i1",    CTL_ALU_R8, 0, 0, 0, 0, DSP, ADDR_PC, 1);
    cyc("irq_i2",    CTL_ALU_R8, 0, 0, 0, 0, PCH | DSP, ADDR_SP, 2);
    cyc("irq_i3",    CTL_ALU_R8, 0, 0, 0, 0, PCL | VEC | ACK, ADDR_SP, 3);
    cyc("irq_i4",    CTL_ALU_R8, 0, 0, 1, 1, F, ADDR_PC, 4);
    cyc("irq_done",  CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);

    cyc("halt_s0",   CTL_HALT, 0, 0, 0, 0, '0, ADDR_PC, 0);
    for (int k = 0; k < 10; k++) cyc("halt_hold", CTL_HALT, 0, 0, 0, 0, HLT, ADDR_PC, 0);
    cyc("halt_stall", CTL_HALT, 0, 1, 1, 0, HLT, ADDR_PC, 0);
    cyc("halt_wake",  CTL_HALT, 0, 0, 1, 0, HLT, ADDR_PC, 0);
    cyc("wake_fetch", CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);
    cyc("wake_run",   CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);

    cyc("haltie_s0",  CTL_HALT, 0, 0, 0, 1, '0, ADDR_PC, 0);
    cyc("haltie_hld", CTL_HALT, 0, 0, 0, 1, HLT, ADDR_PC, 0);
    cyc("haltie_wk",  CTL_HALT, 0, 0, 1, 1, HLT | CLR, ADDR_PC, 0);
    cyc("hirq_i0",    CTL_HALT, 0, 0, 0, 0, '0, ADDR_PC, 0);
    cyc("hirq_i1",    CTL_HALT, 0, 0, 0, 0, DSP, ADDR_PC, 1);
    cyc("hirq_i2",    CTL_HALT, 0, 0, 0, 0, PCH | DSP, ADDR_SP, 2);
    rst_n = 1'b0;
    cyc("hirq_rst",   CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);
    rst_n = 1'b1;
    cyc("rst_boot2",  CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);
    cyc("rst_run2",   CTL_NOP, 0, 0, 0, 0, F, ADDR_PC, 0);

    @(negedge clk); #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sm83_ctl_seq.md
Name: sm83_ctl_seq

Overview:
Parametrised successor to the SM83 fixed 4-slot execute sequencer. It steps a per-op M-cycle sequence of up to MAX_STEPS slots and drives the same datapath strobes as before. New behaviour over the previous sequencer:
- conditional-length sequences (JP cc,a16)
- memory stall
- HALT with wake
- 5-M-cycle interrupt dispatch

It sits between the decoder (ctl_op, alu_op) and the datapath/bus mux.

Parameters:
MAX_STEPS, 8, maximum slots per sequence; must be >=5, checked by an elaboration assertion.
IDX_W, $clog2(MAX_STEPS), width of the step index.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ctl_op  in  ctl_op_t  decoded op of IR
decoded_alu_op  in  alu_op_t  ALU op from decoder
cond_met  in  1  branch condition true (flags vs cc field)
stall  in  1  bus not ready; freeze
int_req  in  1  (IE & IF) != 0
ime  in  1  interrupt master enable
alu_op  out  alu_op_t  always = decoded_alu_op
addr_sel  out  addr_sel_t  PC / GP16 / SP
inc_pc, mem_to_z, mem_to_w, mem_to_ir, mem_to_r8, capture_alu_res, r8_to_alu_op1, update_flags, r8_to_mem, z_to_mem  out  1 each  datapath strobes
wz_to_pc  out  1  PC <= {W,Z}
dec_sp  out  1  SP <= SP-1
pch_to_mem, pcl_to_mem  out  1 each  write PC high/low byte to bus
vec_to_pc  out  1  PC <= vector of highest-priority pending IRQ
irq_ack  out  1  clear that IF bit
clr_ime  out  1  IME <= 0
halt  out  1  high while HALTED
step_idx  out  IDX_W  current slot

Behaviour:
State and outputs:
- Top FSM states: BOOT, RUN, HALTED, IRQ. Step counter idx.
- All outputs are combinational from (state, idx, ctl_op, inputs).
- Default for every strobe is 0; default addr_sel is PC.

Reset:
- Async reset gives state BOOT, idx 0, halt 0.
- BOOT drives mem_to_ir=1 and inc_pc=1, all else 0, then goes to RUN idx0.
- Reset mid-sequence aborts the sequence; no partial strobes follow.

Fetch step:
- A fetch step asserts mem_to_ir and inc_pc in addition to the slot's own strobes.
- On the cycle after a fetch step, idx <= 0.
- On any other slot, idx <= idx+1.

RUN sequences ("F" marks a fetch step):
- LD_R8_D8: s0 mem_to_z+inc_pc; s1 r8_to_alu_op1+capture_alu_res, F.
- LD_R8_R8: s0 r8_to_alu_op1+capture_alu_res, F.
- ALU_R8: s0 r8_to_alu_op1+capture_alu_res+update_flags, F.
- LDPTR_A_R16 / LDPTR_R8_HL: s0 mem_to_z, addr GP16; s1 r8_to_alu_op1+capture_alu_res, F.
- LDPTR_R16_A / LDPTR_HL_R8: s0 r8_to_mem, addr GP16; s1 F.
- LDPTR_HL_D8: s0 mem_to_z+inc_pc; s1 z_to_mem, addr GP16; s2 F.
- JP_D16: s0 mem_to_z+inc_pc; s1 mem_to_w+inc_pc; s2 wz_to_pc; s3 F.
- JP_CC_D16: as JP_D16, but s2 samples cond_met:
  - cond_met=1: s2 wz_to_pc, s3 F (4 M-cycles).
  - cond_met=0: s2 F, no wz_to_pc (3 M-cycles).
- HALT: s0 has no strobes and no fetch; next state HALTED.
- Any other op: s0 F (NOP timing).

Interrupt entry:
- At a RUN fetch step with ime & int_req & !stall: suppress mem_to_ir and inc_pc, assert clr_ime, next state IRQ idx0.
- The exec strobes of that slot still assert.

IRQ sequence:
- i0: no strobes.
- i1: dec_sp.
- i2: pch_to_mem, addr SP, dec_sp.
- i3: pcl_to_mem, addr SP, vec_to_pc, irq_ack.
- i4: F, with no interrupt check. Then RUN idx0.

HALTED:
- halt=1, all strobes 0.
- On int_req=1 and ime=1: clr_ime, next IRQ i0, halt falls.
- On int_req=1 and ime=0: next RUN with a fetch step (BOOT-like), halt falls.

Stall:
- stall=1 forces every strobe to 0 and holds state and idx. addr_sel stays as computed.
- Stall has priority over interrupt entry and halt wake.

Test Plan:
- Reset: rst_n low, then release -> cycle 0 BOOT: mem_to_ir=1, inc_pc=1, halt=0; next cycle RUN idx0.
- JP_CC_D16 with cond_met=0 at s2 -> mem_to_z, mem_to_w, then F at idx2; no wz_to_pc; idx returns to 0 after 3 cycles. Repeat with cond_met=1 -> wz_to_pc at idx2, F at idx3.
- LDPTR_HL_D8 with stall=1 for 2 cycles at s1 -> z_to_mem low for those 2 cycles, high on the 3rd cycle with addr_sel=GP16; step_idx held at 1.
- ALU_R8 with ime=1, int_req=1 -> s0 shows update_flags=1, clr_ime=1, mem_to_ir=0. IRQ then shows:
  - dec_sp at i1 and i2
  - pch_to_mem with addr SP at i2
  - pcl_to_mem, vec_to_pc, irq_ack at i3
  - F at i4
- HALT with ime=0: halt=1 stays high 10 cycles with all strobes 0. Then int_req=1 -> halt=0 next cycle and a single fetch.
- HALT with ime=1: int_req=1 -> clr_ime pulse, IRQ i0-i4 sequence. Asserting rst_n=0 at i2 -> halt=0, BOOT fetch after release.
